// File: rtl/seg7_scan_ctrl_if.sv
// Host/pin-side bundle for the 7-segment scan controller.
// Ports: en, data and load come from the host. dec_in, dig_sel, frame_end and upd_done
//        go to the pins and the host.
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   data;
  logic                  load;
  logic [3:0]            dec_in;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_end;
  logic                  upd_done;

  // master: host side (drives digits and control, observes display outputs)
  modport master (
    output en, data, load,
    input  dec_in, dig_sel, frame_end, upd_done
  );

  // slave: the scan controller itself
  modport slave (
    input  en, data, load,
    output dec_in, dig_sel, frame_end, upd_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double-buffered load.
// Ports: clk, rst (sync, active-high), and bus (slave modport: en/data/load in,
//        dec_in/dig_sel/frame_end/upd_done out; every output is registered).
// Optional: define SEG7_SCAN_LZB_EN to enable leading-zero blanking (digit 0 is never blanked).
module seg7_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_ONE   = DIGITS'(1);

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  phase_t                phase_q, phase_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [SLOT_W-1:0]     slot_q, slot_n;
  logic [4*DIGITS-1:0]   shadow_q, shadow_n;
  logic [4*DIGITS-1:0]   pending_q, pending_n;
  logic                  pend_flag_q, pend_flag_n;

  logic [3:0]            dec_in_q, dec_in_n;
  logic [DIGITS-1:0]     dig_sel_q, dig_sel_n;
  logic                  frame_end_q, frame_end_n;
  logic                  upd_done_q, upd_done_n;
  logic                  blank_digit;

  // ---------------------------------------------------------------------------
  // Slot counters. Disabling the scan parks it at cycle 0 of slot 0 so that
  // re-enabling restarts a clean frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_n  = cnt_q;
    slot_n = slot_q;
    if (!bus.en) begin
      cnt_n  = '0;
      slot_n = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_n  = '0;
      slot_n = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    end else begin
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Load path. frame_end_q marks the current cycle as the frame boundary, so the
  // shadow only ever changes on the edge that starts a new frame. A load landing
  // exactly on the boundary skips the pending buffer.
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_n    = shadow_q;
    pending_n   = pending_q;
    pend_flag_n = pend_flag_q;
    upd_done_n  = 1'b0;
    if (frame_end_q) begin
      if (bus.load) begin
        shadow_n    = bus.data;
        pend_flag_n = 1'b0;
        upd_done_n  = 1'b1;
      end else if (pend_flag_q) begin
        shadow_n    = pending_q;
        pend_flag_n = 1'b0;
        upd_done_n  = 1'b1;
      end
    end else if (bus.load) begin
      pending_n   = bus.data;
      pend_flag_n = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slot phase FSM: state register / next state / outputs.
  // The next phase tracks cnt_n so the registered outputs line up with the
  // counter value of the cycle they are shown in.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) phase_q <= PH_BLANK;
    else     phase_q <= phase_n;
  end

  always_comb begin
    phase_n = phase_q;
    if (!bus.en) begin
      phase_n = PH_BLANK;
    end else begin
      case (phase_q)
        PH_BLANK: if (cnt_n >= CNT_BLANK) phase_n = PH_DRIVE;
        PH_DRIVE: if (cnt_n <  CNT_BLANK) phase_n = PH_BLANK;
        default:  phase_n = PH_BLANK;
      endcase
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  // lead_zero[k] is set when digits k..DIGITS-1 of the next shadow value are all zero.
  logic [DIGITS-1:0] lead_zero;
  logic              zero_run;
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (shadow_n[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end
  assign blank_digit = (slot_n != '0) && lead_zero[slot_n];
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    // Decoder input is presented during blanking too, so segments settle before the enable.
    dec_in_n    = shadow_n[{slot_n, 2'b00} +: 4];
    dig_sel_n   = '0;
    if (phase_n == PH_DRIVE && !blank_digit) begin
      dig_sel_n = SEL_ONE << slot_n;
    end
    frame_end_n = bus.en && (cnt_n == CNT_LAST) && (slot_n == SLOT_LAST);
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      slot_q      <= '0;
      shadow_q    <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      dec_in_q    <= '0;
      dig_sel_q   <= '0;
      frame_end_q <= 1'b0;
      upd_done_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_n;
      slot_q      <= slot_n;
      shadow_q    <= shadow_n;
      pending_q   <= pending_n;
      pend_flag_q <= pend_flag_n;
      dec_in_q    <= dec_in_n;
      dig_sel_q   <= dig_sel_n;
      frame_end_q <= frame_end_n;
      upd_done_q  <= upd_done_n;
    end
  end

  assign bus.dec_in    = dec_in_q;
  assign bus.dig_sel   = dig_sel_q;
  assign bus.frame_end = frame_end_q;
  assign bus.upd_done  = upd_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 (32-cycle frame).
// Cycle 0 is the first cycle after reset is released. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_ctrl_if #(.DIGITS(4)) bus ();

  seg7_scan_ctrl #(
    .DIGITS       (4),
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit has_exp;
  logic [3:0] e_dig;
  logic [3:0] e_dec;
  bit lzb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  initial begin
`ifdef SEG7_SCAN_LZB_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    bus.en   = 1'b1;
    bus.load = 1'b0;
    bus.data = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    while (cyc <= 340) begin
      // ---- stimulus for this cycle (sampled at the next rising edge) ----
      bus.load = 1'b0;
      case (cyc)
        0:   begin bus.load = 1'b1; bus.data = 16'h1234; end
        69:  begin bus.load = 1'b1; bus.data = 16'h1111; end
        84:  begin bus.load = 1'b1; bus.data = 16'h2222; end
        127: begin bus.load = 1'b1; bus.data = 16'h5678; end  // frame-end cycle: bypass
        185: begin bus.load = 1'b1; bus.data = 16'hBA21; end  // captured while disabled
        230: begin bus.load = 1'b1; bus.data = 16'h9999; end  // discarded by reset
        280: begin bus.load = 1'b1; bus.data = 16'h0070; end
        default: ;
      endcase
      bus.en = !(cyc >= 179 && cyc <= 189);
      rst    = (cyc == 240);

      // ---- pulse outputs every cycle ----
      check("frame_end", 32'(bus.frame_end),
            32'(cyc inside {31, 63, 95, 127, 159, 221, 272, 304, 336}));
      check("upd_done", 32'(bus.upd_done),
            32'(cyc inside {32, 96, 128, 222, 305}));

      // ---- hand-computed digit enable / decoder input ----
      has_exp = 1'b1;
      case (cyc)
        0:   begin e_dig = 4'b0000; e_dec = 4'h0; end  // reset state
        5:   begin e_dig = 4'b0001; e_dec = 4'h0; end
        32:  begin e_dig = 4'b0000; e_dec = 4'h4; end  // new frame, blank, presettled
        33:  begin e_dig = 4'b0000; e_dec = 4'h4; end
        34:  begin e_dig = 4'b0001; e_dec = 4'h4; end
        39:  begin e_dig = 4'b0001; e_dec = 4'h4; end
        40:  begin e_dig = 4'b0000; e_dec = 4'h3; end
        41:  begin e_dig = 4'b0000; e_dec = 4'h3; end
        42:  begin e_dig = 4'b0010; e_dec = 4'h3; end
        47:  begin e_dig = 4'b0010; e_dec = 4'h3; end
        90:  begin e_dig = 4'b1000; e_dec = 4'h1; end  // pending not yet shown
        98:  begin e_dig = 4'b0001; e_dec = 4'h2; end  // last load wins
        106: begin e_dig = 4'b0010; e_dec = 4'h2; end
        114: begin e_dig = 4'b0100; e_dec = 4'h2; end
        122: begin e_dig = 4'b1000; e_dec = 4'h2; end
        128: begin e_dig = 4'b0000; e_dec = 4'h8; end  // bypass load applied
        130: begin e_dig = 4'b0001; e_dec = 4'h8; end
        138: begin e_dig = 4'b0010; e_dec = 4'h7; end
        179: begin e_dig = 4'b0100; e_dec = 4'h6; end  // en low this cycle
        180: begin e_dig = 4'b0000; e_dec = 4'h8; end  // dark next cycle
        185: begin e_dig = 4'b0000; e_dec = 4'h8; end
        190: begin e_dig = 4'b0000; e_dec = 4'h8; end  // en back
        191: begin e_dig = 4'b0000; e_dec = 4'h8; end
        192: begin e_dig = 4'b0001; e_dec = 4'h8; end  // lit after 2 blank cycles
        224: begin e_dig = 4'b0001; e_dec = 4'h1; end
        232: begin e_dig = 4'b0010; e_dec = 4'h2; end
        240: begin e_dig = 4'b0100; e_dec = 4'hA; end  // non-BCD passes through
        241: begin e_dig = 4'b0000; e_dec = 4'h0; end  // after reset
        243: begin e_dig = 4'b0001; e_dec = 4'h0; end
        275: begin e_dig = 4'b0001; e_dec = 4'h0; end  // 9999 never displayed
        307: begin e_dig = 4'b0001; e_dec = 4'h0; end
        315: begin e_dig = 4'b0010; e_dec = 4'h7; end
        323: begin e_dig = lzb ? 4'b0000 : 4'b0100; e_dec = 4'h0; end
        331: begin e_dig = lzb ? 4'b0000 : 4'b1000; e_dec = 4'h0; end
        default: begin has_exp = 1'b0; e_dig = 4'b0000; e_dec = 4'h0; end
      endcase
      if (has_exp) begin
        check("dig_sel", 32'(bus.dig_sel), 32'(e_dig));
        check("dec_in",  32'(bus.dec_in),  32'(e_dec));
      end

      // one-hot-or-zero on every cycle
      check("dig_sel_onehot0", 32'($onehot0(bus.dig_sel)), 32'd1);

      @(posedge clk);
      #1;
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
